// File: rtl/word_alu_scheduler.sv
// Round-robin scheduler for one shared multi-cycle W-bit ALU; each result is tagged with its requester id.
// Latency 1+L cycles from grant to rsp_valid (L=1 add/sub/mul/reserved, L=W div/mod/pow); rsp_ready low holds RESP and blocks all grants.
module word_alu_scheduler #(
  parameter int W    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr, gnt, idx;
  logic           gnt_vld;
  logic [2:0]     gnt_op, op_r;
  logic [W-1:0]   a_r, b_r, acc, quo, expo;
  logic [CW-1:0]  cnt;
  logic           long_op, last, ge;
  logic [W:0]     rem_sh;
  logic [W-1:0]   acc_nx, quo_nx, result;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  assign gnt_op    = req_op[3*gnt +: 3];
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign long_op   = (op_r == 3'd3) || (op_r == 3'd4) || (op_r == 3'd5);
  assign last      = !long_op || (cnt == CW'(W - 1));

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (gnt_vld) state_nx = EXEC;
        req_ready[gnt] = gnt_vld & rst;
      end
      EXEC:    if (last) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // div/mod: acc is the partial remainder, quo shifts the dividend out and the quotient in.
  // pow: acc is the running product, quo the repeated square, expo the exponent bits.
  assign rem_sh = {acc, quo[W-1]};
  assign ge     = (rem_sh >= {1'b0, b_r});

  always_comb begin
    acc_nx = acc;
    quo_nx = quo;
    if (op_r == 3'd5) begin
      acc_nx = expo[0] ? W'(acc * quo) : acc;
      quo_nx = W'(quo * quo);
    end else begin
      acc_nx = ge ? W'(rem_sh - {1'b0, b_r}) : rem_sh[W-1:0];
      quo_nx = {quo[W-2:0], ge};
    end
  end

  always_comb begin
    result = '0;
    case (op_r)
      3'd0:    result = a_r + b_r;
      3'd1:    result = a_r - b_r;
      3'd2:    result = a_r * b_r;
      3'd3:    result = quo_nx;
      3'd4:    result = acc_nx;
      3'd5:    result = acc_nx;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      quo      <= '0;
      expo     <= '0;
      cnt      <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            rr_ptr <= IDW'((int'(gnt) + 1) % NREQ);
            op_r   <= gnt_op;
            a_r    <= req_a[W*gnt +: W];
            b_r    <= req_b[W*gnt +: W];
            acc    <= (gnt_op == 3'd5) ? W'(1) : '0;
            quo    <= req_a[W*gnt +: W];
            expo   <= req_b[W*gnt +: W];
            cnt    <= '0;
            rsp_id <= gnt;
          end
        end
        EXEC: begin
          cnt  <= cnt + 1'b1;
          acc  <= acc_nx;
          quo  <= quo_nx;
          expo <= expo >> 1;
          if (last) rsp_data <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_word_alu_scheduler.sv
// Directed bench for word_alu_scheduler: a cycle-level reference model is compared on every negedge,
// and each directed scenario pins the model with hand-computed results, ids and latencies.
module tb_word_alu_scheduler;
  localparam int W = 8, NREQ = 4, IDW = 2;

  logic              clk, rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;

  word_alu_scheduler #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int grant_q[$], gcyc_q[$], rid_q[$], rdat_q[$];
  bit m_work = 0, m_have = 0;
  int m_left = 0, m_ptr = 0, m_id = 0, m_res = 0, m_g = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return (a * b) % 256;
      3: return (b == 0) ? 255 : a / b;
      4: return (b == 0) ? a : a % b;
      5: begin
        r = 1;
        for (int i = 0; i < b; i++) r = (r * a) % 256;
        return r;
      end
      default: return 0;
    endcase
  endfunction

  function automatic int model_lat(input int op);
    return (op >= 3 && op <= 5) ? W : 1;
  endfunction

  // Reference model: idle / working for L cycles / holding a response.
  always @(negedge clk) begin
    if (!rst) begin
      m_work = 0; m_have = 0; m_ptr = 0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
    end else begin
      m_g = -1;
      if (!m_work && !m_have)
        for (int k = 0; k < NREQ; k++)
          if (m_g < 0 && req_valid[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
      chk("req_ready", req_ready, (m_g >= 0) ? (1 << m_g) : 0);
      chk("rsp_valid", rsp_valid, m_have);
      chk("busy", busy, m_work || m_have);
      if (m_have) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_data", rsp_data, m_res);
      end
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) begin
          grant_q.push_back(i);
          gcyc_q.push_back(cyc);
        end
      if (rsp_valid && rsp_ready) begin
        rid_q.push_back(int'(rsp_id));
        rdat_q.push_back(int'(rsp_data));
      end
      if (m_g >= 0) begin
        m_work = 1;
        m_id   = m_g;
        m_res  = model_alu(int'(req_op[3*m_g +: 3]), int'(req_a[W*m_g +: W]), int'(req_b[W*m_g +: W]));
        m_left = model_lat(int'(req_op[3*m_g +: 3]));
        m_ptr  = (m_g + 1) % NREQ;
      end else if (m_work) begin
        m_left--;
        if (m_left == 0) begin m_work = 0; m_have = 1; end
      end else if (m_have && rsp_ready) begin
        m_have = 0;
      end
    end
  end

  task automatic set_req(input int id, input int op, input int a, input int b);
    req_op[3*id +: 3] = 3'(op);
    req_a[W*id +: W]  = W'(a);
    req_b[W*id +: W]  = W'(b);
  endtask

  task automatic do_op(input string nm, input int id, input int op, input int a, input int b,
                       input int exp_d, input int exp_lat);
    int t_acc;
    bit ok;
    t_acc = 0;
    set_req(id, op, a, b);
    req_valid[id] = 1'b1;
    rsp_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin ok = 1; t_acc = cyc; end
    end
    chk({nm, "_granted"}, ok, 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    if (ok) begin
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        if (rsp_valid) begin
          ok = 1;
          chk({nm, "_lat"}, cyc - t_acc, exp_lat);
          chk({nm, "_id"}, rsp_id, id);
          chk({nm, "_data"}, rsp_data, exp_d);
        end
      end
      chk({nm, "_responded"}, ok, 1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int g0, n0, mask;
    bit ok;
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    chk("reset_ready_gated", req_ready, 0);
    chk("reset_busy", busy, 0);
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;

    chk("model_pow_3_5", model_alu(5, 3, 5), 243);
    chk("model_mod_by_0", model_alu(4, 200, 0), 200);
    chk("model_sub_wrap", model_alu(1, 1, 2), 255);

    // T2 fairness
    for (int i = 0; i < NREQ; i++) set_req(i, 0, i, i);
    rsp_ready = 1'b1;
    g0 = grant_q.size();
    n0 = rid_q.size();
    req_valid = '1;
    for (int i = 0; i < 300 && grant_q.size() < g0 + 8; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    chk("fair_grant_count", grant_q.size() - g0, 8);
    if (grant_q.size() >= g0 + 8) begin
      for (int k = 0; k < 8; k++) chk("fair_order", grant_q[g0 + k], k % 4);
      for (int k = 1; k < 8; k++) chk("fair_spacing", gcyc_q[g0 + k] - gcyc_q[g0 + k - 1], 3);
      for (int w = 0; w < 5; w++) begin
        mask = 0;
        for (int k = 0; k < 4; k++) mask |= 1 << grant_q[g0 + w + k];
        chk("fair_window", mask, 15);
      end
    end
    chk("fair_rsp_count", rid_q.size() - n0, 8);
    if (rid_q.size() >= n0 + 4)
      for (int k = 0; k < 4; k++) begin
        chk("fair_rsp_id", rid_q[n0 + k], k);
        chk("fair_rsp_data", rdat_q[n0 + k], 2 * k);
      end

    // T1 chain on requester 0
    do_op("t1_add", 0, 0, 5, 1, 6, 2);
    do_op("t1_pow", 0, 5, 6, 2, 36, 9);
    do_op("t1_sub", 0, 1, 5, 2, 3, 2);
    do_op("t1_mul", 0, 2, 36, 3, 108, 2);
    do_op("t1_div", 0, 3, 108, 3, 36, 9);
    do_op("t1_mod", 0, 4, 36, 6, 0, 9);

    // T3 edges
    do_op("t3_div0", 1, 3, 200, 0, 255, 9);
    do_op("t3_mod0", 2, 4, 200, 0, 200, 9);
    do_op("t3_pow00", 3, 5, 0, 0, 1, 9);
    do_op("t3_pow35", 1, 5, 3, 5, 243, 9);
    do_op("t3_mul_ovf", 2, 2, 16, 16, 0, 2);
    do_op("t3_sub_wrap", 3, 1, 1, 2, 255, 2);
    do_op("t3_pow28", 0, 5, 2, 8, 0, 9);
    do_op("t3_rsvd", 1, 7, 9, 9, 0, 2);

    // T4 backpressure
    set_req(1, 2, 7, 9);
    rsp_ready = 1'b0;
    req_valid[1] = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready[1];
    end
    chk("t4_granted", ok, 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_req(2, 0, 1, 1);
    req_valid[2] = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    chk("t4_rsp_seen", ok, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_id", rsp_id, 1);
      chk("t4_hold_data", rsp_data, 63);
      chk("t4_hold_ready", req_ready, 0);
    end
    n0 = rid_q.size();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t4_one_rsp", rid_q.size() - n0, 1);
    if (rid_q.size() > n0) chk("t4_rsp_id", rid_q[n0], 1);

    // T5 reset during div(255,7)
    set_req(0, 3, 255, 7);
    req_valid[0] = 1'b1;
    n0 = rid_q.size();
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready[0];
    end
    chk("t5_granted", ok, 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk("t5_async_busy", busy, 0);
    chk("t5_async_valid", rsp_valid, 0);
    chk("t5_async_id", rsp_id, 0);
    chk("t5_async_data", rsp_data, 0);
    set_req(2, 0, 2, 2);
    set_req(3, 0, 3, 3);
    req_valid[2] = 1'b1;
    req_valid[3] = 1'b1;
    #1;
    chk("t5_ready_in_reset", req_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    g0 = grant_q.size();
    for (int i = 0; i < 50 && grant_q.size() == g0; i++) @(negedge clk);
    chk("t5_regrant", grant_q.size() > g0, 1);
    if (grant_q.size() > g0) chk("t5_first_grant", grant_q[g0], 2);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_rsp_count", rid_q.size() - n0, 1);
    if (rid_q.size() > n0) begin
      chk("t5_rsp_id", rid_q[n0], 2);
      chk("t5_rsp_data", rdat_q[n0], 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
